// File: rtl/clock_divider_pkg.sv
// Shared defaults and helpers for the multi-channel programmable clock/strobe divider.
package clock_divider_pkg;

   localparam int DEFAULT_CNT_W = 28;
   localparam int DEFAULT_DIV   = 6;
   localparam int DEFAULT_HIGH  = 1;

   // Channel index width; a single channel still needs a 1-bit index.
   function automatic int ch_width(input int n);
      if (n <= 1) begin
         return 1;
      end else begin
         return $clog2(n);
      end
   endfunction

endpackage

// File: rtl/clock_divider_multi_if.sv
// Configuration bus of the divider: write strobe, channel select, new divisor/high-time and pending flags.
interface clock_divider_multi_if
   import clock_divider_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int CNT_W = DEFAULT_CNT_W
);
   localparam int CH_W = ch_width(N_CH);

   logic             cfg_we;
   logic [CH_W-1:0]  cfg_ch;
   logic [CNT_W-1:0] cfg_div;
   logic [CNT_W-1:0] cfg_high;
   logic [N_CH-1:0]  cfg_pending;

   modport master (
      output cfg_we, cfg_ch, cfg_div, cfg_high,
      input  cfg_pending
   );

   modport slave (
      input  cfg_we, cfg_ch, cfg_div, cfg_high,
      output cfg_pending
   );

endinterface

// File: rtl/clock_divider_channel.sv
// One divider channel: period counter, active and shadow divisor/high-time, registered clock and tick.
module clock_divider_channel
   import clock_divider_pkg::*;
#(
   parameter int CNT_W    = DEFAULT_CNT_W,
   parameter int DEF_DIV  = DEFAULT_DIV,
   parameter int DEF_HIGH = DEFAULT_HIGH
)
(
   input  logic             clock_in,
   input  logic             rst,
   input  logic             en,
   input  logic             sync,
   input  logic             wr_en,
   input  logic [CNT_W-1:0] wr_div,
   input  logic [CNT_W-1:0] wr_high,
   output logic             clock_out,
   output logic             tick,
   output logic             pending
);

   localparam logic [CNT_W-1:0] ZERO_C     = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);
   localparam logic [CNT_W-1:0] DEF_DIV_C  = CNT_W'(DEF_DIV);
   localparam logic [CNT_W-1:0] DEF_HIGH_C = CNT_W'(DEF_HIGH);

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] act_div_r;
   logic [CNT_W-1:0] act_high_r;
   logic [CNT_W-1:0] sh_div_r;
   logic [CNT_W-1:0] sh_high_r;
   logic             pend_r;
   logic             clock_out_r;
   logic             tick_r;

   logic             stopped_s;
   logic             last_s;
   logic             apply_s;

   // Period boundary detection and the moments at which the shadow config may become active.
   always_comb begin
      stopped_s = (act_div_r == ZERO_C);
      last_s    = (cnt_r == (act_div_r - ONE_C));
      if (pend_r && (sync || stopped_s || (en && last_s))) begin
         apply_s = 1'b1;
      end else begin
         apply_s = 1'b0;
      end
   end

   // Counter, outputs and config registers; shadow is applied before a same-cycle write lands.
   always_ff @(posedge clock_in) begin
      if (rst) begin
         cnt_r       <= ZERO_C;
         act_div_r   <= DEF_DIV_C;
         act_high_r  <= DEF_HIGH_C;
         sh_div_r    <= DEF_DIV_C;
         sh_high_r   <= DEF_HIGH_C;
         pend_r      <= 1'b0;
         clock_out_r <= 1'b0;
         tick_r      <= 1'b0;
      end else begin
         if (sync || stopped_s) begin
            cnt_r       <= ZERO_C;
            clock_out_r <= 1'b0;
            tick_r      <= 1'b0;
         end else if (en) begin
            clock_out_r <= (cnt_r < act_high_r);
            tick_r      <= last_s;
            cnt_r       <= last_s ? ZERO_C : (cnt_r + ONE_C);
         end else begin
            tick_r      <= 1'b0;
         end

         if (apply_s) begin
            act_div_r  <= sh_div_r;
            act_high_r <= sh_high_r;
         end else begin
            act_div_r  <= act_div_r;
            act_high_r <= act_high_r;
         end

         if (wr_en) begin
            sh_div_r  <= wr_div;
            sh_high_r <= wr_high;
            pend_r    <= 1'b1;
         end else if (apply_s) begin
            pend_r    <= 1'b0;
         end else begin
            pend_r    <= pend_r;
         end
      end
   end

   assign clock_out = clock_out_r;
   assign tick      = tick_r;
   assign pending   = pend_r;

endmodule

// File: rtl/clock_divider_multi.sv
// N-channel programmable clock/strobe divider with shadowed per-channel config and global phase align.
module clock_divider_multi
   import clock_divider_pkg::*;
#(
   parameter int N_CH     = 4,
   parameter int CNT_W    = DEFAULT_CNT_W,
   parameter int DEF_DIV  = DEFAULT_DIV,
   parameter int DEF_HIGH = DEFAULT_HIGH
)
(
   input  logic                 clock_in,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 sync,
   clock_divider_multi_if.slave cfg,
   output logic [N_CH-1:0]      clock_out,
   output logic [N_CH-1:0]      tick
);

   localparam int CH_W = ch_width(N_CH);

   logic [N_CH-1:0] wr_s;
   logic [N_CH-1:0] clock_out_s;
   logic [N_CH-1:0] tick_s;
   logic [N_CH-1:0] pend_s;

   // Indices at or above N_CH match no channel, so such writes are dropped.
   for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      assign wr_s[gi] = cfg.cfg_we && (cfg.cfg_ch == CH_W'(gi));

      clock_divider_channel #(
         .CNT_W    (CNT_W),
         .DEF_DIV  (DEF_DIV),
         .DEF_HIGH (DEF_HIGH)
      ) u_ch (
         .clock_in  (clock_in),
         .rst       (rst),
         .en        (en),
         .sync      (sync),
         .wr_en     (wr_s[gi]),
         .wr_div    (cfg.cfg_div),
         .wr_high   (cfg.cfg_high),
         .clock_out (clock_out_s[gi]),
         .tick      (tick_s[gi]),
         .pending   (pend_s[gi])
      );
   end

   assign clock_out       = clock_out_s;
   assign tick            = tick_s;
   assign cfg.cfg_pending = pend_s;

endmodule

// File: tb/tb_clock_divider_multi.sv
// Bench for clock_divider_multi: directed scenarios plus random traffic against a period-level reference model.
module tb_clock_divider_multi;

   localparam int NCH   = 3;
   localparam int CW    = 28;
   localparam int DDIV  = 6;
   localparam int DHIGH = 1;

   logic clock_in = 1'b0;
   logic rst      = 1'b1;
   logic en       = 1'b0;
   logic sync     = 1'b0;
   logic [NCH-1:0] clock_out;
   logic [NCH-1:0] tick;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference state: position inside the current period and the config governing it.
   int m_pos   [NCH];
   int m_div   [NCH];
   int m_high  [NCH];
   int m_sdiv  [NCH];
   int m_shigh [NCH];
   bit m_pend  [NCH];
   bit m_clk   [NCH];
   bit m_tick  [NCH];

   clock_divider_multi_if #(.N_CH(NCH), .CNT_W(CW)) cfg_bus ();

   clock_divider_multi #(.N_CH(NCH), .CNT_W(CW), .DEF_DIV(DDIV), .DEF_HIGH(DHIGH)) dut (
      .clock_in  (clock_in),
      .rst       (rst),
      .en        (en),
      .sync      (sync),
      .cfg       (cfg_bus),
      .clock_out (clock_out),
      .tick      (tick)
   );

   always #5 clock_in = ~clock_in;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // One rising edge of the reference: what the edge does to each channel given current inputs.
   task automatic model_edge();
      for (int i = 0; i < NCH; i++) begin
         bit restart_to_new;
         if (rst) begin
            m_pos[i] = 0; m_div[i] = DDIV; m_high[i] = DHIGH;
            m_sdiv[i] = DDIV; m_shigh[i] = DHIGH; m_pend[i] = 1'b0;
            m_clk[i] = 1'b0; m_tick[i] = 1'b0;
         end else begin
            restart_to_new = 1'b0;
            if (sync || m_div[i] == 0) begin
               m_pos[i] = 0; m_clk[i] = 1'b0; m_tick[i] = 1'b0;
               restart_to_new = m_pend[i];
            end else if (en) begin
               m_clk[i]  = (m_pos[i] < m_high[i]);
               m_tick[i] = (m_pos[i] == m_div[i] - 1);
               m_pos[i]  = (m_pos[i] + 1) % m_div[i];
               restart_to_new = m_tick[i] && m_pend[i];
            end else begin
               m_tick[i] = 1'b0;
            end
            if (restart_to_new) begin
               m_div[i] = m_sdiv[i]; m_high[i] = m_shigh[i]; m_pend[i] = 1'b0;
            end
            if (cfg_bus.cfg_we && int'(cfg_bus.cfg_ch) == i) begin
               m_sdiv[i] = int'(cfg_bus.cfg_div); m_shigh[i] = int'(cfg_bus.cfg_high);
               m_pend[i] = 1'b1;
            end
         end
      end
   endtask

   // Advance one clock: update the model at the edge, then compare all outputs on the falling edge.
   task automatic step();
      int ec, et, ep;
      @(posedge clock_in);
      model_edge();
      @(negedge clock_in);
      ec = 0; et = 0; ep = 0;
      for (int i = 0; i < NCH; i++) begin
         ec |= int'(m_clk[i]) << i;
         et |= int'(m_tick[i]) << i;
         ep |= int'(m_pend[i]) << i;
      end
      check_val("clock_out", int'(clock_out), ec);
      check_val("tick", int'(tick), et);
      check_val("cfg_pending", int'(cfg_bus.cfg_pending), ep);
   endtask

   task automatic cfg_write(input int ch, input int dv, input int hi);
      cfg_bus.cfg_we   = 1'b1;
      cfg_bus.cfg_ch   = 2'(ch);
      cfg_bus.cfg_div  = CW'(dv);
      cfg_bus.cfg_high = CW'(hi);
      step();
      cfg_bus.cfg_we   = 1'b0;
   endtask

   initial begin
      int waited;
      cfg_bus.cfg_we = 1'b0; cfg_bus.cfg_ch = '0; cfg_bus.cfg_div = '0; cfg_bus.cfg_high = '0;
      step(); step();
      check_val("rst_clock_out", int'(clock_out), 0);
      check_val("rst_tick", int'(tick), 0);
      check_val("rst_pending", int'(cfg_bus.cfg_pending), 0);

      // Defaults: 1 high / 5 low, tick on the 6th cycle.
      rst = 1'b0; en = 1'b1;
      for (int k = 0; k < 12; k++) begin
         step();
         check_val("def_clk0", int'(clock_out[0]), int'(k % 6 == 0));
         check_val("def_tick0", int'(tick[0]), int'(k % 6 == 5));
      end

      // Mid-period reconfiguration of ch1 waits for the wrap.
      step(); step();
      cfg_write(1, 10, 5);
      check_val("ch1_pend_set", int'(cfg_bus.cfg_pending[1]), 1);
      waited = 0;
      while (cfg_bus.cfg_pending[1] && waited < 20) begin step(); waited++; end
      check_val("ch1_pend_clear", int'(cfg_bus.cfg_pending[1]), 0);
      repeat (20) step();

      // Stop ch2, then restart it.
      cfg_write(2, 0, 3);
      repeat (8) step();
      check_val("ch2_stop_clk", int'(clock_out[2]), 0);
      check_val("ch2_stop_tick", int'(tick[2]), 0);
      cfg_write(2, 4, 2);
      repeat (10) step();

      // Freeze.
      step(); step(); step();
      en = 1'b0;
      repeat (7) step();
      en = 1'b1;
      repeat (6) step();

      // Phase align three different divisors.
      cfg_write(0, 3, 1); cfg_write(1, 5, 2); cfg_write(2, 7, 3);
      sync = 1'b1; step(); sync = 1'b0;
      check_val("sync_clk_low", int'(clock_out), 0);
      step();
      check_val("sync_clk_rise", int'(clock_out), 7);
      repeat (25) step();

      // Out-of-range index, high beyond divisor, reset during sync.
      cfg_write(3, 9, 9);
      check_val("oor_ignored", int'(cfg_bus.cfg_pending), 0);
      cfg_write(0, 4, 8);
      repeat (12) step();
      check_val("const_high", int'(clock_out[0]), 1);
      rst = 1'b1; sync = 1'b1; step(); rst = 1'b0; sync = 1'b0;
      check_val("rst_sync_pend", int'(cfg_bus.cfg_pending), 0);
      repeat (8) step();

      // Largest divisor.
      cfg_write(1, (1 << CW) - 1, 1 << (CW - 1));
      sync = 1'b1; step(); sync = 1'b0;
      repeat (30) step();

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         rst  = ($urandom_range(0, 299) == 0);
         sync = ($urandom_range(0, 59) == 0);
         en   = ($urandom_range(0, 9) != 0);
         cfg_bus.cfg_we   = ($urandom_range(0, 7) == 0);
         cfg_bus.cfg_ch   = 2'($urandom_range(0, 3));
         cfg_bus.cfg_div  = CW'($urandom_range(0, 9));
         cfg_bus.cfg_high = CW'($urandom_range(0, 11));
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
